lsu_rmw: RTL and testbench
==========================

# lsu_rmw

Load/store unit between the execute stage and the word-wide data memory (256 × 32-bit, word-indexed, synchronous write, combinational read, whole-word writes only). Accepts one RISC-V load/store per handshake. Handles all byte/halfword/word formats: little-endian lane selection and sign/zero extension on loads, read-modify-write for SB/SH. Flags misaligned, out-of-range and illegal accesses without touching memory.

## Interface
Parameters:
- MEM_WORDS, 256, number of 32-bit words in data memory; word index ≥ MEM_WORDS is out of range

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid & req_ready at a rising edge
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (access size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  access rejected; qualified by resp_valid
- mem_we  out  1  data-memory write enable
- mem_a  out  32  data-memory word index = {2'b00, addr[31:2]}
- mem_wd  out  32  data-memory write data
- mem_rd  in  32  data-memory read data (combinational)

## Operation
- States: IDLE, ACCESS, WRITE, RESP. Registered request fields captured on acceptance.
- IDLE: req_ready=1. On acceptance: if error → RESP (err); else → ACCESS.
- Errors, checked at acceptance: funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ MEM_WORDS. On error mem_we never asserted, resp_rdata=0.
- ACCESS: mem_a = registered word index.
  - Load: register formatted mem_rd into resp_rdata → RESP.
  - SW: mem_we=1, mem_wd=wdata → RESP.
  - SB/SH: latch mem_rd, merge wdata[7:0] into byte lane addr[1:0] (bits 8·k+7:8·k) or wdata[15:0] into half lane addr[1] → WRITE.
- WRITE: mem_we=1, mem_wd=merged word → RESP.
- RESP: resp_valid=1 one cycle, → IDLE. req_ready=0 in ACCESS, WRITE, RESP; requests then ignored (no buffering).
- Load formats: LB/LH sign-extend from bit 7/15 of selected lane; LBU/LHU zero-extend; LW whole word.
- mem_we is 1 only in ACCESS(SW) and WRITE; decoded from state, never from inputs.

## Timing
- Reset (async, immediate): state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_a=0, mem_wd=0, all captured registers 0.
- Acceptance edge E0. Load/SW: ACCESS E0–E1, resp_valid E1–E2 (SW write commits at E1). SB/SH: ACCESS E0–E1, WRITE E1–E2 (commit at E2), resp_valid E2–E3. Error: resp_valid E0–E1.
- Next acceptance earliest at the edge ending RESP+1 cycle (IDLE); throughput one access per 3 (load/SW), 4 (SB/SH), 2 (error) cycles.
- resp_rdata/resp_err hold until the next RESP overwrites them.
- Reset mid-operation: mem_we drops asynchronously in the same cycle; an in-progress SB/SH/SW leaves memory unchanged; no resp_valid is produced for the aborted request.
- req_valid deassertion after acceptance has no effect.

## Test plan
- Reset with rst_n=0 mid-clock → all outputs 0 immediately, req_ready=1 after release.
- SW addr 0x10 data 0xDEADBEEF → mem_a=4, mem_we=1 one cycle, resp_valid 2 cycles after accept; LW 0x10 → resp_rdata 0xDEADBEEF, resp_err=0.
- SB addr 0x11 data 0x000000A5 on 0xDEADBEEF → word 0xDEADA5EF, resp_valid 3 cycles after accept; LB 0x11 → 0xFFFFFFA5; LBU 0x11 → 0x000000A5.
- SH addr 0x12 data 0x00008001 → word 0x8001A5EF; LH 0x12 → 0xFFFF8001; LHU 0x12 → 0x00008001.
- Errors: LW 0x13, SH 0x11, LB 0x400 (MEM_WORDS=256), load funct3=011 → each resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, mem_we never 1, memory unchanged; req_valid held during busy → single response only.
- Assert rst_n=0 during WRITE of SB 0x10 data 0x77 → mem_we falls immediately, word 0x10 keeps prior value, no resp_valid, next LW 0x10 returns prior value.

Source files
------------

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit between execute and a word-wide data memory.
// Accepts one RISC-V load/store per handshake. Loads select a little-endian
// lane and sign/zero extend it. SB/SH are read-modify-write because the
// memory only takes whole-word writes. Bad accesses are rejected without
// ever touching memory.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only when idle)
//   req_we, req_funct3   store flag and RISC-V access size/sign
//   req_addr, req_wdata  byte address and store data
//   resp_valid           one-cycle response strobe
//   resp_rdata/resp_err  formatted load data / rejection flag (held)
//   mem_we/mem_a/mem_wd  data-memory write enable, word index, write data
//   mem_rd               data-memory combinational read data
module lsu_rmw #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, merge_q;

    logic        accept, fmt_bad, mis, oor, bad;
    logic        is_sw;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_fmt, merged;

    assign accept = req_valid && (state == IDLE);

    // Request legality, decided from the live request at acceptance.
    always_comb begin
        fmt_bad = 1'b0;
        mis     = 1'b0;
        case (req_funct3)
            3'b000: ;
            3'b001: mis = req_addr[0];
            3'b010: mis = |req_addr[1:0];
            3'b100: fmt_bad = req_we;          // LBU has no store form
            3'b101: begin
                fmt_bad = req_we;              // LHU has no store form
                mis     = req_addr[0];
            end
            default: fmt_bad = 1'b1;
        endcase
    end

    assign oor = {2'b00, req_addr[31:2]} >= MEM_WORDS;
    assign bad = fmt_bad | mis | oor;

    // Only legal stores reach ACCESS, so a store with funct3 != 010 is SB/SH.
    assign is_sw = we_q && (f3_q == 3'b010);

    always_comb begin
        byte_lane = mem_rd[{addr_q[1:0], 3'b000} +: 8];
        half_lane = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_fmt = {24'h0, byte_lane};
            3'b001:  load_fmt = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_fmt = {16'h0, half_lane};
            default: load_fmt = mem_rd;
        endcase
    end

    always_comb begin
        merged = mem_rd;
        if (f3_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (addr_q[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0]  = wdata_q[15:0];
    end

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = bad ? RESP : ACCESS;
            ACCESS:  state_nx = (we_q && !is_sw) ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request capture and response registers. The response registers are
    // only written on the transition into RESP, so they hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    if (bad) begin
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        resp_rdata <= load_fmt;
                        resp_err   <= 1'b0;
                    end else if (is_sw) begin
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                    end else begin
                        merge_q <= merged;
                    end
                end
                WRITE: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Memory-side strobes come from state only, so reset kills a pending
    // write immediately.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_we     = (state == WRITE) || ((state == ACCESS) && is_sw);
    assign mem_a      = {2'b00, addr_q[31:2]};
    assign mem_wd     = (state == WRITE)                 ? merge_q :
                        ((state == ACCESS) && is_sw)     ? wdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: table of directed vectors, reset-abort sequences and
// randomized requests checked against a byte-addressed memory model.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

    int errors = 0;
    int checks = 0;

    lsu_rmw #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous whole-word write, combinational read.
    logic [31:0] mem [0:255] = '{default: 32'h0};
    always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;
    assign mem_rd = mem[mem_a[7:0]];

    // Reference: memory as plain little-endian bytes.
    logic [7:0] rb [0:1023] = '{default: 8'h0};

    function automatic logic [31:0] ref_word(input int w);
        return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
    endfunction

    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic err,
                                  output int lat);
        int n;
        logic legal;
        n     = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        err   = !legal || (addr % n != 0) || (addr >= 32'd1024);
        rd    = 32'h0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < n; i++) rb[addr + i] = wd[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
        end else begin
            for (int i = 0; i < n; i++) rd = rd | (32'(rb[addr + i]) << (8*i));
            if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
            lat = 2;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one request (req_valid held through busy) and collect response.
    // Entry/exit: 1 time unit after a rising edge.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er,
                           output int lat, output int wes);
        int n = 0;
        rd = 32'h0; er = 1'b0; lat = 0; wes = 0;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!req_ready) chk("ready_timeout", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            #1;
            if (mem_we) begin
                wes++;
                chk("mem_a", mem_a, {2'b00, addr[31:2]});
            end
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
            end else begin
                @(posedge clk);
            end
        end
        req_valid = 1'b0;
        if (lat == 0) chk("resp_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        chk("single_resp", {31'h0, resp_valid}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } vec_t;

    vec_t        tbl [22];
    logic [31:0] rd, erd, prior;
    logic        er, eer;
    int          lat, elat, wes, seen;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr, rwd;

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        tbl[2]  = '{1'b1, 3'b000, 32'h11,  32'h000000A5, 32'h0,        1'b0, 3, 1};
        tbl[3]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0, 2, 0};
        tbl[4]  = '{1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFA5, 1'b0, 2, 0};
        tbl[5]  = '{1'b0, 3'b100, 32'h11,  32'h0,        32'h000000A5, 1'b0, 2, 0};
        tbl[6]  = '{1'b1, 3'b001, 32'h12,  32'h00008001, 32'h0,        1'b0, 3, 1};
        tbl[7]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h8001A5EF, 1'b0, 2, 0};
        tbl[8]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 1'b0, 2, 0};
        tbl[9]  = '{1'b0, 3'b101, 32'h12,  32'h0,        32'h00008001, 1'b0, 2, 0};
        tbl[10] = '{1'b0, 3'b001, 32'h10,  32'h0,        32'hFFFFA5EF, 1'b0, 2, 0};
        tbl[11] = '{1'b0, 3'b010, 32'h13,  32'h0,        32'h0,        1'b1, 1, 0};
        tbl[12] = '{1'b1, 3'b001, 32'h11,  32'h1234,     32'h0,        1'b1, 1, 0};
        tbl[13] = '{1'b0, 3'b000, 32'h400, 32'h0,        32'h0,        1'b1, 1, 0};
        tbl[14] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 1, 0};
        tbl[15] = '{1'b1, 3'b100, 32'h10,  32'h55,       32'h0,        1'b1, 1, 0};
        tbl[16] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h8001A5EF, 1'b0, 2, 0};
        tbl[17] = '{1'b1, 3'b000, 32'h3FF, 32'h00000080, 32'h0,        1'b0, 3, 1};
        tbl[18] = '{1'b0, 3'b000, 32'h3FF, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
        tbl[19] = '{1'b0, 3'b001, 32'h3FE, 32'h0,        32'hFFFF8000, 1'b0, 2, 0};
        tbl[20] = '{1'b0, 3'b010, 32'h3FC, 32'h0,        32'h80000000, 1'b0, 2, 0};
        tbl[21] = '{1'b1, 3'b010, 32'h400, 32'h11111111, 32'h0,        1'b1, 1, 0};

        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_valid",  {31'h0, resp_valid}, 32'h0);
        chk("rst_err",    {31'h0, resp_err},   32'h0);
        chk("rst_rdata",  resp_rdata, 32'h0);
        chk("rst_mem",    {31'h0, mem_we} | mem_a | mem_wd, 32'h0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        foreach (tbl[i]) begin
            run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat, wes);
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, erd, eer, elat);
            chk($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
            chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, tbl[i].err});
            chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_we", i), wes, tbl[i].wes);
        end

        // Reset mid-clock during a SW ACCESS: write must not land.
        prior = ref_word(8);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("sw_access_we", {31'h0, mem_we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sw_we",    {31'h0, mem_we},     32'h0);
        chk("abort_sw_ready", {31'h0, req_ready},  32'h1);
        chk("abort_sw_outs",  resp_rdata | mem_a | mem_wd | {31'h0, resp_err | resp_valid}, 32'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (resp_valid) seen++; end
        chk("abort_sw_noresp", seen, 0);
        chk("abort_sw_mem", mem[8], prior);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // Reset during WRITE of SB 0x10.
        prior = ref_word(4);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("sb_write_we", {31'h0, mem_we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sb_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin @(posedge clk); #1; if (resp_valid) seen++; end
        chk("abort_sb_noresp", seen, 0);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, wes);
        chk("abort_sb_lw", rd, prior);

        // Randomized requests against the byte model.
        for (int i = 0; i < 80; i++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            rwd = $urandom;
            case ($urandom_range(0, 9))
                0:       raddr = $urandom;
                1, 2, 3: raddr = 32'($urandom_range(0, 1023));
                default: raddr = 32'($urandom_range(0, 31));
            endcase
            run_req(rwe, rf3, raddr, rwd, rd, er, lat, wes);
            model(rwe, rf3, raddr, rwd, erd, eer, elat);
            chk($sformatf("r%0d_rdata a=%h f=%0d we=%0d", i, raddr, rf3, rwe), rd, erd);
            chk($sformatf("r%0d_err", i), {31'h0, er}, {31'h0, eer});
            chk($sformatf("r%0d_lat", i), lat, elat);
            chk($sformatf("r%0d_we", i), wes, (!eer && rwe) ? 1 : 0);
        end

        // Whole memory image against the model.
        seen = -1;
        for (int w = 0; w < 256; w++)
            if (seen < 0 && mem[w] !== ref_word(w)) seen = w;
        chk("mem_image_first_bad_word", seen, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
